// File: rtl/jam_pkg.sv
// Shared definitions for the JAM solver and its cost-table loader.
// Matrix size, word widths, loader state encodings and the cost word type.
package jam_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned CW    = 7;
  localparam int unsigned LBW   = 10;
  localparam int unsigned DEPTH = N * N;

  typedef logic [CW-1:0] cost_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic cost_t cost_min(input cost_t a, input cost_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/jam_cost_loader_if.sv
// Valid/ready word stream carrying the row-major cost matrix into the loader.
interface jam_cost_loader_if;

  logic            in_valid;
  logic            in_ready;
  jam_pkg::cost_t  in_data;
  logic            in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/jam_row_min_acc.sv
// Tracks the running minimum of the current row and accumulates the
// row minimums into the lower bound.
module jam_row_min_acc
  import jam_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  input  logic           beat,
  input  cost_t          data,
  input  logic           row_end,
  input  logic           clear,
  output logic [LBW-1:0] acc
);

  cost_t row_min;
  cost_t cand;

  assign cand = cost_min(row_min, data);

  // The row's final word folds straight into acc so row_min is free for the next row.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      row_min <= '1;
      acc     <= '0;
    end else if (beat) begin
      if (row_end) begin
        acc     <= acc + LBW'(cand);
        row_min <= '1;
      end else begin
        row_min <= cand;
      end
    end
  end

endmodule

// File: rtl/jam_cost_loader.sv
// Loads the 8x8 cost matrix from a word stream, serves zero-latency cost
// lookups to JAM and reports the sum of row minimums as a lower bound.
module jam_cost_loader
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  jam_cost_loader_if.slave in_bus,
  input  logic             reload,
  input  logic [2:0]       W,
  input  logic [2:0]       J,
  output cost_t            Cost,
  output logic             table_ready,
  output logic [LBW-1:0]   LowerBound,
  output logic             load_err
);

  state_t         state;
  state_t         next_state;
  logic [5:0]     idx;
  cost_t          mem [DEPTH];
  logic           ready;
  logic           accept;
  logic           row_end;
  logic           clear;
  logic [LBW-1:0] acc;

  assign in_bus.in_ready = ready;
  assign accept          = in_bus.in_valid & ready;

  // An early in_last poisons the table, so its beat must not close a row.
  assign row_end = accept && (idx[2:0] == 3'd7) &&
                   ((idx == 6'd63) || !in_bus.in_last);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    ready       = 1'b0;
    table_ready = 1'b0;
    load_err    = 1'b0;
    clear       = 1'b0;
    unique case (state)
      LOAD: begin
        ready = 1'b1;
        if (accept) begin
          if (idx == 6'd63) begin
            next_state = in_bus.in_last ? DONE : ERR;
          end else if (in_bus.in_last) begin
            next_state = ERR;
          end
        end
      end
      DONE: begin
        table_ready = 1'b1;
        if (reload) begin
          next_state = LOAD;
          clear      = 1'b1;
        end
      end
      ERR: begin
        load_err = 1'b1;
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      idx <= '0;
    end else if (accept) begin
      idx <= idx + 6'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[idx] <= in_bus.in_data;
    end
  end

  jam_row_min_acc u_row_min_acc (
    .CLK     (CLK),
    .RST     (RST),
    .beat    (accept),
    .data    (in_bus.in_data),
    .row_end (row_end),
    .clear   (clear),
    .acc     (acc)
  );

  assign Cost       = table_ready ? mem[{W, J}] : '0;
  assign LowerBound = table_ready ? acc : '0;

endmodule

// File: tb/tb_jam_cost_loader.sv
// Directed bench for jam_cost_loader: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_jam_cost_loader;
  import jam_pkg::*;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           reload = 1'b0;
  logic [2:0]     W = '0;
  logic [2:0]     J = '0;
  cost_t          Cost;
  logic           table_ready;
  logic           load_err;
  logic [LBW-1:0] LowerBound;

  jam_cost_loader_if bus ();

  jam_cost_loader dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_bus      (bus),
    .reload      (reload),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .table_ready (table_ready),
    .LowerBound  (LowerBound),
    .load_err    (load_err)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_COST, K_TR, K_LB, K_ERR, K_RDY} kind_t;
  typedef struct {
    string name;
    kind_t kind;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      int   act;
      e = sb.pop_front();
      case (e.kind)
        K_COST:  act = int'(Cost);
        K_TR:    act = int'(table_ready);
        K_LB:    act = int'(LowerBound);
        K_ERR:   act = int'(load_err);
        default: act = int'(bus.in_ready);
      endcase
      vectors++;
      if (act != e.val) begin
        miscompares++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string n, input kind_t k, input int v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  function automatic cost_t val(input int mode, input int w, input int j);
    case (mode)
      0:       return cost_t'(w + j);
      1:       return cost_t'(127);
      default: return (j == 7 - w) ? cost_t'(10 + w) : cost_t'(120);
    endcase
  endfunction

  task automatic cost_chk(input int w, input int j, input int e);
    W = 3'(w);
    J = 3'(j);
    chk("cost", K_COST, e);
    step();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    chk("reload_tr_hold", K_TR, 1);
    step();
    reload = 1'b0;
    chk("reload_tr_drop", K_TR, 0);
    chk("reload_rdy", K_RDY, 1);
  endtask

  task automatic load_table(input int mode, input bit toggle, input int last_at, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (toggle) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 7'h55;
        bus.in_last  = 1'b1;
        if (b == 5) chk("idle_rdy", K_RDY, 1);
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = val(mode, b / 8, b % 8);
      bus.in_last  = (b == last_at);
      if (b == nbeats - 1) begin
        chk("pre_tr", K_TR, 0);
        chk("pre_err", K_ERR, 0);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) step();
    RST = 1'b0;
    W = 3'd3;
    J = 3'd5;
    chk("rst_rdy", K_RDY, 1);
    chk("rst_tr", K_TR, 0);
    chk("rst_err", K_ERR, 0);
    chk("rst_lb", K_LB, 0);
    chk("rst_cost", K_COST, 0);
    step();

    // w+j table, continuous valid
    load_table(0, 1'b0, 63, 64);
    chk("t1_tr", K_TR, 1);
    chk("t1_lb", K_LB, 28);
    chk("t1_rdy", K_RDY, 0);
    chk("t1_err", K_ERR, 0);
    cost_chk(3, 5, 8);
    cost_chk(7, 7, 14);
    cost_chk(7, 0, 7);

    // reload with all-127
    do_reload();
    load_table(1, 1'b0, 63, 64);
    chk("t5_tr", K_TR, 1);
    chk("t5_lb", K_LB, 1016);
    cost_chk(2, 6, 127);
    cost_chk(5, 1, 127);

    // w+j table with gaps in valid
    do_reload();
    load_table(0, 1'b1, 63, 64);
    chk("t2_tr", K_TR, 1);
    chk("t2_lb", K_LB, 28);
    cost_chk(4, 4, 8);

    // reset mid-load, then anti-diagonal table
    do_reload();
    load_table(2, 1'b0, -1, 31);
    RST = 1'b1;
    step();
    RST = 1'b0;
    W = 3'd0;
    J = 3'd7;
    chk("t6_rdy", K_RDY, 1);
    chk("t6_tr", K_TR, 0);
    chk("t6_err", K_ERR, 0);
    chk("t6_cost", K_COST, 0);
    step();
    load_table(2, 1'b0, 63, 64);
    chk("t6_tr_done", K_TR, 1);
    chk("t6_lb", K_LB, 108);
    cost_chk(0, 7, 10);
    cost_chk(0, 0, 120);
    cost_chk(7, 0, 17);
    cost_chk(3, 4, 13);

    // early in_last
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
    load_table(0, 1'b0, 10, 11);
    chk("t3_err", K_ERR, 1);
    chk("t3_rdy", K_RDY, 0);
    chk("t3_tr", K_TR, 0);
    reload = 1'b1;
    step();
    reload = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    chk("t3_err_hold", K_ERR, 1);
    chk("t3_rdy_hold", K_RDY, 0);
    chk("t3_tr_hold", K_TR, 0);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("t3_err_clr", K_ERR, 0);
    chk("t3_rdy_clr", K_RDY, 1);
    step();

    // missing in_last
    load_table(0, 1'b0, -1, 64);
    W = 3'd3;
    J = 3'd5;
    chk("t4_err", K_ERR, 1);
    chk("t4_tr", K_TR, 0);
    chk("t4_rdy", K_RDY, 0);
    chk("t4_cost", K_COST, 0);
    step();

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
